// File: rtl/sorted_loader_if.sv
// Bus bundle for sorted_loader: insert handshake, search-side read port and status.
// Handshake: Load is taken only in a cycle where Ready=1 and Full=0; Done pulses one
// cycle after the value is written. Load while Ready=0 is dropped, and Load while Full
// produces a one-cycle Overflow pulse.
interface sorted_loader_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 5
);
    logic [WIDTH-1:0] Data_In;
    logic             Load;
    logic [AW-1:0]    Rd_Addr;
    logic [WIDTH-1:0] Rd_Data;
    logic             Ready;
    logic             Done;
    logic [AW-1:0]    Insert_Pos;
    logic [AW:0]      Count;
    logic             Full;
    logic             Overflow;
    logic             dbg_state;

    modport master (
        output Data_In, Load, Rd_Addr,
        input  Rd_Data, Ready, Done, Insert_Pos, Count, Full, Overflow, dbg_state
    );

    modport slave (
        input  Data_In, Load, Rd_Addr,
        output Rd_Data, Ready, Done, Insert_Pos, Count, Full, Overflow, dbg_state
    );
endinterface

// File: rtl/sorted_loader.sv
// Insertion-sort fill stage: keeps a DEPTH x WIDTH array in ascending unsigned order,
// shifting one larger element up per cycle until the new value's slot is found.
// A registered read port lets the search stage address the array directly.
module sorted_loader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic Clock,
    input  logic Reset,
    sorted_loader_if.slave bus
);
    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_SHIFT  = 1'b1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [AW:0]      idx_q, idx_d;
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    pos_q, pos_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] rd_q;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [AW-1:0]    idx_m1;
    logic [WIDTH-1:0] prev_val;
    logic             full;

    assign full     = (count_q == FULL_CNT);
    assign idx_m1   = idx_q[AW-1:0] - 1'b1;
    assign prev_val = mem_q[idx_m1];

    // Next-state logic: accept/reject loads in IDLE, shift-or-insert in SHIFT
    always_comb begin
        state_d   = state_q;
        d_d       = d_q;
        idx_d     = idx_q;
        count_d   = count_q;
        pos_d     = pos_q;
        done_d    = 1'b0;
        ovf_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = idx_q[AW-1:0];
        mem_wdata = d_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Load) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        d_d     = bus.Data_In;
                        idx_d   = count_q;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                // Stop at the first element <= D so equal values keep arrival order
                if (idx_q == '0 || prev_val <= d_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = d_q;
                    pos_d     = idx_q[AW-1:0];
                    count_d   = full ? count_q : count_q + 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    mem_we    = 1'b1;
                    mem_wdata = prev_val;
                    idx_d     = idx_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and status registers; reset aborts any insertion in progress
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            idx_q   <= '0;
            count_q <= '0;
            pos_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            pos_q   <= pos_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Array storage; contents survive reset, only writes are suppressed during it
    always_ff @(posedge Clock) begin
        if (mem_we && !Reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read port; addresses beyond the valid range read as zero
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_q <= '0;
        end else if ({1'b0, bus.Rd_Addr} < count_q) begin
            rd_q <= mem_q[bus.Rd_Addr];
        end else begin
            rd_q <= '0;
        end
    end

    assign bus.Rd_Data    = rd_q;
    assign bus.Ready      = (state_q == S_IDLE);
    assign bus.Done       = done_q;
    assign bus.Insert_Pos = pos_q;
    assign bus.Count      = count_q;
    assign bus.Full       = full;
    assign bus.Overflow   = ovf_q;
    assign bus.dbg_state  = state_q[0];
endmodule

// File: tb/tb_sorted_loader.sv
// Directed bench for sorted_loader: vector tables for the basic insert sequence plus
// hand-written sequences for ordering, fill-to-full, held Load and mid-insert reset.
module tb_sorted_loader;
    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sorted_loader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    sorted_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0] din;
        int         shifts;
        logic [4:0] pos;
        logic [5:0] cnt;
    } ld_vec_t;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } rd_vec_t;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference array: new value goes after every stored value <= it
    task automatic model_insert(input logic [7:0] v, output int pos);
        pos = 0;
        foreach (exp_q[i]) if (exp_q[i] <= v) pos = i + 1;
        exp_q.insert(pos, v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        bus.Load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Present one value, then count busy cycles until Ready returns
    task automatic do_load(input logic [7:0] v, input bit hold, output int shifts,
                           output logic [4:0] pos, output logic [5:0] cnt, output logic done);
        @(negedge clk);
        bus.Data_In = v;
        bus.Load    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.Load = 1'b0;
        shifts = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.Ready) break;
            shifts++;
        end
        bus.Load = 1'b0;
        done = bus.Done;
        pos  = bus.Insert_Pos;
        cnt  = bus.Count;
    endtask

    task automatic load_chk(input string tag, input logic [7:0] v, input bit hold,
                            input int exp_shifts, input logic [4:0] exp_pos, input logic [5:0] exp_cnt);
        int         shifts;
        int         mpos;
        logic [4:0] pos;
        logic [5:0] cnt;
        logic       done;
        do_load(v, hold, shifts, pos, cnt, done);
        model_insert(v, mpos);
        check({tag, ".shifts"}, shifts, exp_shifts);
        check({tag, ".ready"}, bus.Ready, 1);
        check({tag, ".done"}, done, 1);
        check({tag, ".pos"}, pos, exp_pos);
        check({tag, ".pos_model"}, pos, mpos);
        check({tag, ".count"}, cnt, exp_cnt);
        check({tag, ".count_model"}, cnt, exp_q.size());
        check({tag, ".no_ovf"}, bus.Overflow, 0);
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.Rd_Addr = a;
        @(negedge clk);
        d = bus.Rd_Data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        ld_vec_t    t1[4];
        rd_vec_t    r1[5];
        logic [7:0] d;

        t1[0] = '{8'h05, 1, 5'd0, 6'd1};
        t1[1] = '{8'h03, 2, 5'd0, 6'd2};
        t1[2] = '{8'h09, 1, 5'd2, 6'd3};
        t1[3] = '{8'h03, 3, 5'd1, 6'd4};
        r1[0] = '{5'd0, 8'h03};
        r1[1] = '{5'd1, 8'h03};
        r1[2] = '{5'd2, 8'h05};
        r1[3] = '{5'd3, 8'h09};
        r1[4] = '{5'd4, 8'h00};

        rst         = 1'b1;
        bus.Load    = 1'b0;
        bus.Data_In = '0;
        bus.Rd_Addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst.ready", bus.Ready, 1);
        check("rst.count", bus.Count, 0);
        check("rst.done", bus.Done, 0);
        check("rst.ovf", bus.Overflow, 0);
        check("rst.pos", bus.Insert_Pos, 0);
        check("rst.rdata", bus.Rd_Data, 0);
        check("rst.full", bus.Full, 0);

        // Basic insert sequence from the table
        for (int i = 0; i < 4; i++) begin
            load_chk($sformatf("t1[%0d]", i), t1[i].din, 1'b0, t1[i].shifts, t1[i].pos, t1[i].cnt);
            if (i == 0) begin
                @(negedge clk);
                check("t1.done_pulse", bus.Done, 0);
            end
        end
        for (int i = 0; i < 5; i++) begin
            rd(r1[i].addr, d);
            check($sformatf("t1.rd[%0d]", i), d, r1[i].data);
        end

        // Extremes: 0xFF then 0x00
        do_reset();
        load_chk("t2.ff", 8'hFF, 1'b0, 1, 5'd0, 6'd1);
        load_chk("t2.00", 8'h00, 1'b0, 2, 5'd0, 6'd2);
        rd(5'd0, d); check("t2.rd0", d, 8'h00);
        rd(5'd1, d); check("t2.rd1", d, 8'hFF);
        rd(5'd2, d); check("t2.rd2", d, 8'h00);

        // Unsigned order and stable placement of equal values
        do_reset();
        load_chk("t6.80a", 8'h80, 1'b0, 1, 5'd0, 6'd1);
        load_chk("t6.7f", 8'h7F, 1'b0, 2, 5'd0, 6'd2);
        load_chk("t6.80b", 8'h80, 1'b0, 1, 5'd2, 6'd3);
        for (int i = 0; i < 3; i++) begin
            rd(5'(i), d);
            check($sformatf("t6.rd[%0d]", i), d, exp_q[i]);
        end

        // Fill with descending values: every insert shifts the whole array
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            load_chk($sformatf("t3.ld[%0d]", i), 8'(31 - i), 1'b0, i + 1, 5'd0, 6'(i + 1));
        end
        check("t3.full", bus.Full, 1);
        for (int i = 0; i < DEPTH; i++) begin
            rd(5'(i), d);
            check($sformatf("t3.rd[%0d]", i), d, i);
        end
        @(negedge clk);
        bus.Data_In = 8'h55;
        bus.Load    = 1'b1;
        @(posedge clk);
        #1;
        bus.Load = 1'b0;
        @(negedge clk);
        check("t3.ovf", bus.Overflow, 1);
        check("t3.ovf_nodone", bus.Done, 0);
        check("t3.ovf_ready", bus.Ready, 1);
        check("t3.ovf_count", bus.Count, 32);
        @(negedge clk);
        check("t3.ovf_pulse", bus.Overflow, 0);
        check("t3.ovf_count2", bus.Count, 32);
        rd(5'd31, d); check("t3.rd31_after", d, 8'd31);

        // Load held high during an insertion: only the first is taken
        do_reset();
        load_chk("t4.10", 8'd10, 1'b0, 1, 5'd0, 6'd1);
        load_chk("t4.20", 8'd20, 1'b0, 1, 5'd1, 6'd2);
        load_chk("t4.05", 8'd5, 1'b1, 3, 5'd0, 6'd3);
        @(negedge clk);
        check("t4.idle_after", bus.Ready, 1);
        check("t4.count_after", bus.Count, 3);
        check("t4.no_ovf", bus.Overflow, 0);
        rd(5'd0, d); check("t4.rd0", d, 8'd5);
        rd(5'd1, d); check("t4.rd1", d, 8'd10);
        rd(5'd2, d); check("t4.rd2", d, 8'd20);

        // Reset during the 2nd SHIFT cycle of a 4-shift insert
        do_reset();
        load_chk("t5.10", 8'd10, 1'b0, 1, 5'd0, 6'd1);
        load_chk("t5.20", 8'd20, 1'b0, 1, 5'd1, 6'd2);
        load_chk("t5.30", 8'd30, 1'b0, 1, 5'd2, 6'd3);
        @(negedge clk);
        bus.Data_In = 8'd5;
        bus.Load    = 1'b1;
        @(posedge clk);
        #1;
        bus.Load = 1'b0;
        @(negedge clk);
        check("t5.busy", bus.Ready, 0);
        @(negedge clk);
        check("t5.busy2", bus.Ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t5.rst_ready", bus.Ready, 1);
        check("t5.rst_count", bus.Count, 0);
        check("t5.rst_done", bus.Done, 0);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t5.no_late_done", bus.Done, 0);
        load_chk("t5.07", 8'd7, 1'b0, 1, 5'd0, 6'd1);
        rd(5'd0, d); check("t5.rd0", d, 8'd7);
        rd(5'd1, d); check("t5.rd1", d, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
